// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexed 7-segment driver with per-slot anti-ghost blanking and frame-synchronous shadow registers.
// Optional build macro SCAN_SKIP_EN: slot advance skips digits whose latched enable bit is 0.
module digit_scanner #(
  parameter int N_DIGITS = 8,
  parameter int DIV = 100000,
  parameter int BLANK = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_DIGITS*8-1:0]         seg_data,
  input  logic [N_DIGITS-1:0]           digit_en,
  output logic [N_DIGITS-1:0]           an_n,
  output logic [7:0]                    seg_n,
  output logic [$clog2(N_DIGITS)-1:0]   sel_idx,
  output logic                          frame_start
);
  localparam int SW = $clog2(N_DIGITS);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK);
  typedef enum logic [1:0] {IDLE, BLNK, SHOW} state_t;
  state_t state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [N_DIGITS*8-1:0] seg_sh, nxt_seg;
  logic [N_DIGITS-1:0] en_sh, nxt_en;
  logic [SW-1:0] adv_idx, nxt_sel;
  logic adv_wrap, nxt_latch, nxt_show;
`ifdef SCAN_SKIP_EN
  logic [SW-1:0] tgt, first_idx;
  // Next enabled digit after the current one; a target at or below the current index closes the frame,
  // and the new frame opens on the lowest enabled digit of the freshly latched mask.
  always_comb begin
    tgt = '0;
    first_idx = '0;
    for (int i = N_DIGITS; i >= 1; i--)
      if (en_sh[(int'(sel_idx) + i) % N_DIGITS]) tgt = SW'((int'(sel_idx) + i) % N_DIGITS);
    for (int i = N_DIGITS - 1; i >= 0; i--)
      if (digit_en[i]) first_idx = SW'(i);
    adv_wrap = tgt <= sel_idx;
    adv_idx = adv_wrap ? first_idx : tgt;
  end
`else
  assign adv_wrap = sel_idx == SW'(N_DIGITS - 1);
  assign adv_idx = adv_wrap ? '0 : sel_idx + 1'b1;
`endif
  // Next slot position and shadow contents; shadows reload only at frame start so a frame never tears.
  always_comb begin
    nxt_latch = (state == IDLE) || (cnt == LAST && adv_wrap);
    nxt_cnt = (state == IDLE || cnt == LAST) ? '0 : cnt + 1'b1;
    nxt_sel = (state == IDLE) ? '0 : (cnt == LAST) ? adv_idx : sel_idx;
    nxt_seg = nxt_latch ? seg_data : seg_sh;
    nxt_en = nxt_latch ? digit_en : en_sh;
    nxt_show = (nxt_cnt >= BL) && nxt_en[nxt_sel];
  end
  // Scan FSM with all outputs registered from the next-slot view.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state <= IDLE;
      cnt <= '0;
      sel_idx <= '0;
      frame_start <= 1'b0;
      an_n <= '1;
      seg_n <= '1;
      if (rst) begin
        seg_sh <= '1;
        en_sh <= '0;
      end
    end else begin
      state <= (nxt_cnt < BL) ? BLNK : SHOW;
      cnt <= nxt_cnt;
      sel_idx <= nxt_sel;
      frame_start <= nxt_latch;
      seg_sh <= nxt_seg;
      en_sh <= nxt_en;
      an_n <= nxt_show ? ~(N_DIGITS'(1) << nxt_sel) : '1;
      seg_n <= nxt_show ? nxt_seg[8*int'(nxt_sel) +: 8] : '1;
    end
  end
endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: randomized self-checking bench against a frame/slot-time reference model.
module tb_digit_scanner;
  localparam int ND = 8;
  localparam int DIV = 10;
  localparam int BLANK = 2;
`ifdef SCAN_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct packed {
    logic run;
    int t;
    int len;
    logic [ND-1:0][2:0] ord;
    logic [ND*8-1:0] seg;
    logic [ND-1:0] msk;
    logic [ND-1:0] an;
    logic [7:0] sg;
    logic [2:0] sel;
    logic fs;
  } mdl_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [ND*8-1:0] seg_data = '0;
  logic [ND-1:0] digit_en = '0;
  logic [ND-1:0] an_n;
  logic [7:0] seg_n;
  logic [2:0] sel_idx;
  logic frame_start;
  int checks = 0;
  int failures = 0;
  mdl_t mdl;
  always #5 clk = ~clk;
  digit_scanner #(.N_DIGITS(ND), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .seg_data(seg_data), .digit_en(digit_en),
    .an_n(an_n), .seg_n(seg_n), .sel_idx(sel_idx), .frame_start(frame_start)
  );
  // Reference: time t since frame start, the frame's visiting order, slot = order[t/DIV], blanked while t%DIV < BLANK.
  function automatic mdl_t model_next(mdl_t m, logic r, logic e, logic [ND*8-1:0] sd, logic [ND-1:0] de);
    mdl_t n = m;
    int s;
    if (r || !e) begin
      n.run = 1'b0; n.t = 0; n.an = '1; n.sg = '1; n.sel = '0; n.fs = 1'b0;
      if (r) begin n.seg = '1; n.msk = '0; end
      return n;
    end
    n.fs = !m.run || (m.t == m.len * DIV - 1);
    if (n.fs) begin
      n.t = 0; n.len = 0; n.seg = sd; n.msk = de;
      for (int i = 0; i < ND; i++)
        if (!SKIP || de[i] || (i == 0 && !m.run)) begin n.ord[n.len] = 3'(i); n.len++; end
      if (n.len == 0) begin n.ord[0] = 3'd0; n.len = 1; end
    end else n.t = m.t + 1;
    n.run = 1'b1;
    s = int'(n.ord[n.t / DIV]);
    n.sel = 3'(s);
    n.an = (n.t % DIV >= BLANK && n.msk[s]) ? ~(8'd1 << s) : '1;
    n.sg = (n.t % DIV >= BLANK && n.msk[s]) ? n.seg[8*s +: 8] : '1;
    return n;
  endfunction
  always @(posedge clk) mdl <= model_next(mdl, rst, en, seg_data, digit_en);
  // No cycle may ever drive two anodes at once.
  always @(negedge clk)
    if (!$isunknown(an_n))
      assert ($countones(~an_n) <= 1) else begin
        failures++;
        $display("FAIL onehot an_n=%h has more than one low bit", an_n);
      end
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; digit_en = '1; seg_data = {$urandom, $urandom};
    repeat (3) begin
      @(negedge clk); checks++;
      if ({an_n, seg_n, sel_idx, frame_start} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
        failures++; $display("FAIL reset_state got an=%h seg=%h sel=%0d fs=%b exp FF FF 0 0", an_n, seg_n, sel_idx, frame_start);
      end
    end
    rst = 1'b0;
    @(negedge clk); checks++;
    if ({frame_start, sel_idx, an_n} !== {1'b1, 3'd0, 8'hFF}) begin
      failures++; $display("FAIL start got fs=%b sel=%0d an=%h exp 1 0 FF", frame_start, sel_idx, an_n);
    end
    @(negedge clk); checks++;
    if ({frame_start, an_n, seg_n} !== {1'b0, 8'hFF, 8'hFF}) begin
      failures++; $display("FAIL blank2 got fs=%b an=%h seg=%h exp 0 FF FF", frame_start, an_n, seg_n);
    end
    repeat (8) begin
      @(negedge clk); checks++;
      if ({an_n, seg_n} !== {8'hFE, seg_data[7:0]}) begin
        failures++; $display("FAIL show0 got an=%h seg=%h exp FE %h", an_n, seg_n, seg_data[7:0]);
      end
    end
  endtask
  task automatic test_free_run();
    int last = -1;
    int gaps = 0;
    for (int i = 0; i < 240; i++) begin
      seg_data = {$urandom, $urandom};
      @(negedge clk); checks++;
      if ({an_n, seg_n, sel_idx, frame_start} !== {mdl.an, mdl.sg, mdl.sel, mdl.fs}) begin
        failures++; $display("FAIL free_run got an=%h seg=%h sel=%0d fs=%b exp an=%h seg=%h sel=%0d fs=%b",
          an_n, seg_n, sel_idx, frame_start, mdl.an, mdl.sg, mdl.sel, mdl.fs);
      end
      if (frame_start) begin
        if (last >= 0) begin
          checks++; gaps++;
          if (i - last != 80) begin failures++; $display("FAIL frame_period got %0d exp 80", i - last); end
        end
        last = i;
      end
    end
    checks++;
    if (gaps < 2) begin failures++; $display("FAIL frame_count got %0d intervals exp >=2", gaps); end
  endtask
  task automatic test_midframe();
    logic [7:0] old;
    seg_data = {$urandom, $urandom};
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (frame_start) break; end
    checks++;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL mid_wait got fs=%b exp 1", frame_start); end
    old = seg_data[31:24];
    repeat (15) @(negedge clk);
    seg_data[31:24] = ~old;
    repeat (20) @(negedge clk);
    checks++;
    if ({an_n, seg_n} !== {8'hF7, old}) begin
      failures++; $display("FAIL mid_old got an=%h seg=%h exp F7 %h", an_n, seg_n, old);
    end
    repeat (80) @(negedge clk);
    checks++;
    if ({an_n, seg_n} !== {8'hF7, ~old}) begin
      failures++; $display("FAIL mid_new got an=%h seg=%h exp F7 %h", an_n, seg_n, ~old);
    end
  endtask
  task automatic test_mask();
    int len = 0;
    bit seen0 = 0;
    bit seen2 = 0;
    digit_en = 8'b0000_0101;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (frame_start) break; end
    checks++;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL mask_wait got fs=%b exp 1", frame_start); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); len++; checks++;
      if ({an_n, seg_n, sel_idx, frame_start} !== {mdl.an, mdl.sg, mdl.sel, mdl.fs}) begin
        failures++; $display("FAIL mask_model got an=%h seg=%h sel=%0d fs=%b exp an=%h seg=%h sel=%0d fs=%b",
          an_n, seg_n, sel_idx, frame_start, mdl.an, mdl.sg, mdl.sel, mdl.fs);
      end
      if (an_n == 8'hFE) seen0 = 1;
      if (an_n == 8'hFB) seen2 = 1;
      checks++;
      if (an_n != 8'hFF && an_n != 8'hFE && an_n != 8'hFB) begin
        failures++; $display("FAIL mask_anode got an=%h exp FF/FE/FB", an_n);
      end
      if (frame_start) break;
    end
    checks++;
    if (len != (SKIP ? 20 : 80)) begin failures++; $display("FAIL mask_period got %0d exp %0d", len, SKIP ? 20 : 80); end
    checks++;
    if (!(seen0 && seen2)) begin failures++; $display("FAIL mask_seen got fe=%b fb=%b exp 1 1", seen0, seen2); end
    digit_en = '1;
  endtask
  task automatic test_en_drop();
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (an_n != 8'hFF) break; end
    checks++;
    if (an_n == 8'hFF) begin failures++; $display("FAIL drop_wait got an=%h exp not FF", an_n); end
    en = 1'b0;
    @(negedge clk); checks++;
    if ({an_n, seg_n, sel_idx, frame_start} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
      failures++; $display("FAIL drop got an=%h seg=%h sel=%0d fs=%b exp FF FF 0 0", an_n, seg_n, sel_idx, frame_start);
    end
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk); checks++;
    if ({frame_start, sel_idx, an_n} !== {1'b1, 3'd0, 8'hFF}) begin
      failures++; $display("FAIL restart got fs=%b sel=%0d an=%h exp 1 0 FF", frame_start, sel_idx, an_n);
    end
  endtask
  task automatic test_rst_mid();
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (sel_idx == 3'd5) break; end
    repeat (4) @(negedge clk);
    checks++;
    if ({sel_idx, an_n} !== {3'd5, 8'hDF}) begin
      failures++; $display("FAIL slot5 got sel=%0d an=%h exp 5 DF", sel_idx, an_n);
    end
    rst = 1'b1;
    @(negedge clk); checks++;
    if ({an_n, seg_n, sel_idx, frame_start} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
      failures++; $display("FAIL rst_mid got an=%h seg=%h sel=%0d fs=%b exp FF FF 0 0", an_n, seg_n, sel_idx, frame_start);
    end
    rst = 1'b0;
    @(negedge clk); checks++;
    if ({frame_start, sel_idx} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL rst_restart got fs=%b sel=%0d exp 1 0", frame_start, sel_idx);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(99) == 0;
      en = $urandom_range(24) != 0;
      if ($urandom_range(29) == 0) digit_en = ($urandom_range(3) == 0) ? '0 : ND'($urandom);
      seg_data = {$urandom, $urandom};
      @(negedge clk); checks++;
      if ({an_n, seg_n, sel_idx, frame_start} !== {mdl.an, mdl.sg, mdl.sel, mdl.fs}) begin
        failures++; $display("FAIL random got an=%h seg=%h sel=%0d fs=%b exp an=%h seg=%h sel=%0d fs=%b",
          an_n, seg_n, sel_idx, frame_start, mdl.an, mdl.sg, mdl.sel, mdl.fs);
      end
    end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_midframe();
    test_mask();
    test_en_drop();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
